// File: rtl/tlb_assoc_pcid_pkg.sv
// Shared types and helpers for the PCID-tagged set-associative TLB.
package tlb_pkg;

  typedef enum logic [0:0] {IDLE, INV_WALK} tlb_state_e;

  // Entries are stored at the widest supported field sizes; the top module
  // zero-extends its narrower fields so one struct serves every configuration.
  localparam int MAX_WAYS   = 64;
  localparam int MAX_LG     = 6;
  localparam int MAX_TAG_W  = 64;
  localparam int MAX_PPN_W  = 64;
  localparam int MAX_PCID_W = 32;

  typedef logic [MAX_WAYS-2:0] plru_bits_t;

  typedef struct packed {
    logic                  valid;
    logic                  glob;
    logic [MAX_PCID_W-1:0] pcid;
    logic [MAX_TAG_W-1:0]  tag;
    logic [MAX_PPN_W-1:0]  ppn;
  } tlb_entry_t;

  function automatic int idx_w(int sets);
    return $clog2(sets);
  endfunction

  function automatic int tag_w(int va_w, int page_shift, int sets);
    return va_w - page_shift - $clog2(sets);
  endfunction

  // Heap-ordered tree: node n has children 2n+1 (lower half) and 2n+2.
  function automatic int plru_victim(plru_bits_t bits, int lg);
    int node = 0;
    int way  = 0;
    for (int l = 0; l < MAX_LG; l++) begin
      if (l < lg) begin
        way  = (way << 1) | int'(bits[node[5:0]]);
        node = 2 * node + 1 + int'(bits[node[5:0]]);
      end
    end
    return way;
  endfunction

  // Each node on the path is set to point at the half not containing 'way'.
  function automatic plru_bits_t plru_touch(plru_bits_t bits, int way, int lg);
    plru_bits_t nb = bits;
    int node = 0;
    logic d;
    for (int l = 0; l < MAX_LG; l++) begin
      if (l < lg) begin
        d = ((way >> (lg - 1 - l)) & 1) != 0;
        nb[node[5:0]] = ~d;
        node = 2 * node + 1 + int'(d);
      end
    end
    return nb;
  endfunction

endpackage

// File: rtl/tlb_assoc_pcid_if.sv
// Lookup / insert / invalidate bus between requesters and the TLB.
interface tlb_assoc_pcid_if #(
  parameter int VA_W   = 64,
  parameter int PA_W   = 64,
  parameter int PCID_W = 12
);
  logic              lk_valid;
  logic              lk_ready;
  logic [VA_W-1:0]   lk_va;
  logic [PCID_W-1:0] lk_pcid;
  logic              rsp_valid;
  logic              rsp_hit;
  logic              rsp_miss;
  logic [PA_W-1:0]   rsp_pa;
  logic              ins_valid;
  logic              ins_ready;
  logic [VA_W-1:0]   ins_va;
  logic [PA_W-1:0]   ins_pa;
  logic [PCID_W-1:0] ins_pcid;
  logic              ins_global;
  logic              inv_valid;
  logic              inv_all;
  logic [PCID_W-1:0] inv_pcid;
  logic              inv_busy;

  modport master (
    output lk_valid, lk_va, lk_pcid, ins_valid, ins_va, ins_pa, ins_pcid,
           ins_global, inv_valid, inv_all, inv_pcid,
    input  lk_ready, rsp_valid, rsp_hit, rsp_miss, rsp_pa, ins_ready, inv_busy
  );

  modport slave (
    input  lk_valid, lk_va, lk_pcid, ins_valid, ins_va, ins_pa, ins_pcid,
           ins_global, inv_valid, inv_all, inv_pcid,
    output lk_ready, rsp_valid, rsp_hit, rsp_miss, rsp_pa, ins_ready, inv_busy
  );
endinterface

// File: rtl/tlb_assoc_pcid_plru_tree.sv
// Tree-PLRU state for one TLB set: victim choice and touch update.
module plru_tree
  import tlb_pkg::*;
#(
  parameter int WAYS = 8
) (
  input  logic                    clk,
  input  logic                    shutdown,
  input  logic                    touch_en,
  input  logic [$clog2(WAYS)-1:0] touch_way,
  output logic [$clog2(WAYS)-1:0] victim
);
  localparam int LG = $clog2(WAYS);

  logic [WAYS-2:0] bits_q;
  plru_bits_t      bits_ext;
  plru_bits_t      bits_nxt;

  assign bits_ext = plru_bits_t'(bits_q);
  assign victim   = LG'(plru_victim(bits_ext, LG));
  assign bits_nxt = plru_touch(bits_ext, int'(touch_way), LG);

  // Tree bits clear on reset and move away from each touched way.
  always_ff @(posedge clk) begin
    if (shutdown) bits_q <= '0;
    else if (touch_en) bits_q <= bits_nxt[WAYS-2:0];
  end
endmodule

// File: rtl/tlb_assoc_pcid.sv
// Set-associative TLB with PCID tags, global pages and an invalidate walker.
module tlb_assoc_pcid
  import tlb_pkg::*;
#(
  parameter int WAYS       = 8,
  parameter int SETS       = 8,
  parameter int VA_W       = 64,
  parameter int PA_W       = 64,
  parameter int PCID_W     = 12,
  parameter int PAGE_SHIFT = 12
) (
  input logic             clk,
  input logic             shutdown,
  tlb_assoc_pcid_if.slave bus
);
  localparam int IDX_W = idx_w(SETS);
  localparam int TAG_W = tag_w(VA_W, PAGE_SHIFT, SETS);
  localparam int PPN_W = PA_W - PAGE_SHIFT;
  localparam int WAY_W = $clog2(WAYS);

  tlb_entry_t        ent [SETS][WAYS];
  tlb_state_e        state;
  logic [IDX_W-1:0]  walk_idx;
  logic              inv_all_q;
  logic [PCID_W-1:0] inv_pcid_q;

  logic             ready, lk_fire, ins_fire;
  logic [IDX_W-1:0] lk_idx, ins_idx;
  logic [TAG_W-1:0] lk_tag, ins_tag;
  logic             lk_hit;
  logic [WAY_W-1:0] lk_way, ins_way, match_way, free_way;
  logic             have_match, have_free;
  logic [PPN_W-1:0] lk_ppn;
  logic [WAY_W-1:0] victim   [SETS];
  logic             touch_en [SETS];
  logic [WAY_W-1:0] touch_way[SETS];

  // An invalidate pulse blocks lookups and inserts in the same cycle.
  assign ready         = (state == IDLE) && !bus.inv_valid;
  assign bus.lk_ready  = ready;
  assign bus.ins_ready = ready;
  assign bus.inv_busy  = (state == INV_WALK);
  assign lk_fire       = bus.lk_valid && ready;
  assign ins_fire      = bus.ins_valid && ready;
  assign lk_idx        = bus.lk_va[PAGE_SHIFT +: IDX_W];
  assign lk_tag        = bus.lk_va[VA_W-1 -: TAG_W];
  assign ins_idx       = bus.ins_va[PAGE_SHIFT +: IDX_W];
  assign ins_tag       = bus.ins_va[VA_W-1 -: TAG_W];

  // Lookup compare on the pre-insert contents; lowest matching way wins.
  always_comb begin
    lk_hit = 1'b0;
    lk_way = '0;
    lk_ppn = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (ent[lk_idx][w].valid && ent[lk_idx][w].tag == MAX_TAG_W'(lk_tag) &&
          (ent[lk_idx][w].glob || ent[lk_idx][w].pcid == MAX_PCID_W'(bus.lk_pcid))) begin
        lk_hit = 1'b1;
        lk_way = WAY_W'(w);
        lk_ppn = ent[lk_idx][w].ppn[PPN_W-1:0];
      end
    end
  end

  // Insert way: same-identity overwrite, then first free way, then PLRU victim.
  always_comb begin
    have_match = 1'b0;
    match_way  = '0;
    have_free  = 1'b0;
    free_way   = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (ent[ins_idx][w].valid && ent[ins_idx][w].tag == MAX_TAG_W'(ins_tag) &&
          ent[ins_idx][w].glob == bus.ins_global &&
          (bus.ins_global || ent[ins_idx][w].pcid == MAX_PCID_W'(bus.ins_pcid))) begin
        have_match = 1'b1;
        match_way  = WAY_W'(w);
      end
      if (!ent[ins_idx][w].valid) begin
        have_free = 1'b1;
        free_way  = WAY_W'(w);
      end
    end
    ins_way = have_match ? match_way : (have_free ? free_way : victim[ins_idx]);
  end

  // Per-set PLRU touch; an insert into the set overrides a lookup hit there.
  always_comb begin
    for (int s = 0; s < SETS; s++) begin
      touch_en[s]  = 1'b0;
      touch_way[s] = '0;
      if (ins_fire && ins_idx == IDX_W'(s)) begin
        touch_en[s]  = 1'b1;
        touch_way[s] = ins_way;
      end else if (lk_fire && lk_hit && lk_idx == IDX_W'(s)) begin
        touch_en[s]  = 1'b1;
        touch_way[s] = lk_way;
      end
    end
  end

  for (genvar s = 0; s < SETS; s++) begin : g_plru
    plru_tree #(.WAYS(WAYS)) u_plru (
      .clk      (clk),
      .shutdown (shutdown),
      .touch_en (touch_en[s]),
      .touch_way(touch_way[s]),
      .victim   (victim[s])
    );
  end

  // Registered one-cycle lookup response.
  always_ff @(posedge clk) begin
    if (shutdown) begin
      bus.rsp_valid <= 1'b0;
      bus.rsp_hit   <= 1'b0;
      bus.rsp_miss  <= 1'b0;
      bus.rsp_pa    <= '0;
    end else begin
      bus.rsp_valid <= lk_fire;
      bus.rsp_hit   <= lk_fire && lk_hit;
      bus.rsp_miss  <= lk_fire && !lk_hit;
      bus.rsp_pa    <= (lk_fire && lk_hit) ? {lk_ppn, bus.lk_va[PAGE_SHIFT-1:0]} : '0;
    end
  end

  // Walker FSM and entry storage: inserts in IDLE, one set per cycle in INV_WALK.
  always_ff @(posedge clk) begin
    if (shutdown) begin
      state      <= IDLE;
      walk_idx   <= '0;
      inv_all_q  <= 1'b0;
      inv_pcid_q <= '0;
      for (int s = 0; s < SETS; s++)
        for (int w = 0; w < WAYS; w++)
          ent[s][w].valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.inv_valid) begin
            state      <= INV_WALK;
            walk_idx   <= '0;
            inv_all_q  <= bus.inv_all;
            inv_pcid_q <= bus.inv_pcid;
          end
          if (ins_fire)
            ent[ins_idx][ins_way] <= '{valid: 1'b1, glob: bus.ins_global,
                                      pcid: MAX_PCID_W'(bus.ins_pcid),
                                      tag: MAX_TAG_W'(ins_tag),
                                      ppn: MAX_PPN_W'(bus.ins_pa[PA_W-1:PAGE_SHIFT])};
        end
        INV_WALK: begin
          for (int w = 0; w < WAYS; w++)
            if (inv_all_q || (!ent[walk_idx][w].glob &&
                              ent[walk_idx][w].pcid == MAX_PCID_W'(inv_pcid_q)))
              ent[walk_idx][w].valid <= 1'b0;
          walk_idx <= walk_idx + 1'b1;
          if (walk_idx == IDX_W'(SETS - 1)) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_tlb_assoc_pcid.sv
// Self-checking bench: directed vector table, walker/reset sequences, random vs model.
module tb_tlb_assoc_pcid;
  localparam int SETS = 8;
  localparam int WAYS = 8;

  logic clk = 1'b0;
  logic shutdown = 1'b1;
  int checks = 0;
  int failures = 0;

  tlb_assoc_pcid_if #(.VA_W(64), .PA_W(64), .PCID_W(12)) bus ();

  tlb_assoc_pcid #(.WAYS(WAYS), .SETS(SETS), .VA_W(64), .PA_W(64),
                   .PCID_W(12), .PAGE_SHIFT(12)) dut (
    .clk     (clk),
    .shutdown(shutdown),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    bit          lk;
    bit          ins;
    logic [63:0] va;
    logic [63:0] pa;
    logic [11:0] pcid;
    bit          glob;
    bit          ehit;
    logic [63:0] epa;
  } vec_t;

  vec_t vecs[$];

  // Reference model: plain arrays, tag = va>>15, index = va[14:12], ppn = pa>>12.
  bit          mv   [SETS][WAYS];
  bit          mg   [SETS][WAYS];
  logic [11:0] mp   [SETS][WAYS];
  logic [48:0] mt   [SETS][WAYS];
  logic [51:0] mppn [SETS][WAYS];
  bit          mtree[SETS][WAYS-1];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.lk_valid = 0; bus.ins_valid = 0; bus.inv_valid = 0; bus.inv_all = 0;
    bus.ins_global = 0;
  endtask

  task automatic m_reset();
    for (int s = 0; s < SETS; s++) begin
      for (int w = 0; w < WAYS; w++) mv[s][w] = 0;
      for (int n = 0; n < WAYS - 1; n++) mtree[s][n] = 0;
    end
  endtask

  // Walk the tree by halving the way range; a 0 bit descends into the lower half.
  function automatic int m_victim(int s);
    int node = 0, lo = 0, size = WAYS;
    while (size > 1) begin
      if (mtree[s][node] == 0) node = 2 * node + 1;
      else begin lo += size / 2; node = 2 * node + 2; end
      size /= 2;
    end
    return lo;
  endfunction

  task automatic m_touch(input int s, input int w);
    int node = 0, lo = 0, size = WAYS;
    while (size > 1) begin
      if (w < lo + size / 2) begin mtree[s][node] = 1; node = 2 * node + 1; end
      else begin mtree[s][node] = 0; lo += size / 2; node = 2 * node + 2; end
      size /= 2;
    end
  endtask

  task automatic m_lookup(input logic [63:0] va, input logic [11:0] pcid,
                          output bit hit, output logic [63:0] pa, output int way);
    int s = int'(va[14:12]);
    hit = 0; pa = 0; way = 0;
    for (int w = 0; w < WAYS; w++)
      if (!hit && mv[s][w] && mt[s][w] == va[63:15] && (mg[s][w] || mp[s][w] == pcid)) begin
        hit = 1; way = w; pa = {mppn[s][w], va[11:0]};
      end
  endtask

  task automatic m_insert(input logic [63:0] va, input logic [63:0] pa,
                          input logic [11:0] pcid, input bit glob);
    int s = int'(va[14:12]);
    int w = -1;
    for (int i = 0; i < WAYS; i++)
      if (w < 0 && mv[s][i] && mt[s][i] == va[63:15] && mg[s][i] == glob &&
          (glob || mp[s][i] == pcid)) w = i;
    for (int i = 0; i < WAYS; i++)
      if (w < 0 && !mv[s][i]) w = i;
    if (w < 0) w = m_victim(s);
    mv[s][w] = 1; mg[s][w] = glob; mp[s][w] = pcid; mt[s][w] = va[63:15];
    mppn[s][w] = pa[63:12];
    m_touch(s, w);
  endtask

  task automatic m_invalidate(input bit all, input logic [11:0] pcid);
    for (int s = 0; s < SETS; s++)
      for (int w = 0; w < WAYS; w++)
        if (all || (!mg[s][w] && mp[s][w] == pcid)) mv[s][w] = 0;
  endtask

  task automatic do_insert(input logic [63:0] va, input logic [63:0] pa,
                           input logic [11:0] pcid, input bit glob);
    bus.ins_valid = 1; bus.ins_va = va; bus.ins_pa = pa; bus.ins_pcid = pcid;
    bus.ins_global = glob;
    tick();
    bus.ins_valid = 0; bus.ins_global = 0;
  endtask

  task automatic do_lookup(input string name, input logic [63:0] va, input logic [11:0] pcid,
                           input bit ehit, input logic [63:0] epa);
    bus.lk_valid = 1; bus.lk_va = va; bus.lk_pcid = pcid;
    tick();
    bus.lk_valid = 0;
    chk({name, "_valid"}, 64'(bus.rsp_valid), 64'd1);
    chk({name, "_hit"}, {62'd0, bus.rsp_hit, bus.rsp_miss}, {62'd0, ehit, !ehit});
    chk({name, "_pa"}, bus.rsp_pa, epa);
  endtask

  // Counts busy cycles after an accepted invalidate; lookups must stay blocked.
  task automatic wait_walk(input string name);
    int n = 0;
    while (bus.inv_busy && n < 40) begin
      chk({name, "_lk_ready_busy"}, 64'(bus.lk_ready), 64'd0);
      n++;
      tick();
    end
    chk({name, "_busy_len"}, 64'(n), 64'd8);
  endtask

  task automatic pulse_inv(input bit all, input logic [11:0] pcid);
    bus.inv_valid = 1; bus.inv_all = all; bus.inv_pcid = pcid;
    #1;
    chk("inv_blocks_ready", {62'd0, bus.lk_ready, bus.ins_ready}, 64'd0);
    tick();
    bus.inv_valid = 0; bus.inv_all = 0;
  endtask

  initial begin
    logic [63:0] vff, vg, vs, va, pa;
    logic [11:0] pcid;
    logic [48:0] tg;
    bit          do_lk, do_ins, glob, mhit;
    logic [63:0] mpa;
    int          mway, r;

    idle_inputs();
    bus.lk_va = 0; bus.lk_pcid = 0; bus.ins_va = 0; bus.ins_pa = 0; bus.ins_pcid = 0;
    bus.inv_pcid = 0;
    tick(); tick();
    shutdown = 0;
    tick();
    chk("rst_rsp", {60'd0, bus.rsp_valid, bus.rsp_hit, bus.rsp_miss, bus.inv_busy}, 64'd0);
    chk("rst_rsp_pa", bus.rsp_pa, 64'd0);
    chk("rst_ready", {62'd0, bus.lk_ready, bus.ins_ready}, 64'd3);

    vff = 64'hFFFF_FFFF_FFFF_FFF1;
    vg  = 64'h0000_0000_0ABC_D234;
    vs  = 64'h0000_0000_0004_2777;
    vecs.push_back('{1, 0, vff, 64'd0, 12'd0, 0, 0, 64'd0});
    vecs.push_back('{0, 1, vff, 64'd0, 12'd0, 0, 0, 64'd0});
    vecs.push_back('{1, 0, vff, 64'd0, 12'd0, 0, 1, 64'h0000_0000_0000_0FF1});
    vecs.push_back('{1, 0, vff, 64'd0, 12'd1, 0, 0, 64'd0});
    vecs.push_back('{0, 1, vg, 64'h0000_0000_1234_5999, 12'd5, 1, 0, 64'd0});
    vecs.push_back('{1, 0, vg, 64'd0, 12'd0, 0, 1, 64'h0000_0000_1234_5234});
    vecs.push_back('{1, 0, vg, 64'd0, 12'd1, 0, 1, 64'h0000_0000_1234_5234});
    vecs.push_back('{1, 0, vg, 64'd0, 12'hFFF, 0, 1, 64'h0000_0000_1234_5234});
    for (int t = 1; t <= 9; t++)
      vecs.push_back('{0, 1, 64'(t) << 15, 64'(t + 256) << 12, 12'd0, 0, 0, 64'd0});
    vecs.push_back('{1, 0, (64'd1 << 15) | 64'h123, 64'd0, 12'd0, 0, 0, 64'd0});
    for (int t = 2; t <= 9; t++)
      vecs.push_back('{1, 0, (64'(t) << 15) | 64'h123, 64'd0, 12'd0, 0, 1,
                       (64'(t + 256) << 12) | 64'h123});
    vecs.push_back('{1, 1, vs, 64'h0000_0000_ABCD_E000, 12'd3, 0, 0, 64'd0});
    vecs.push_back('{1, 0, vs, 64'd0, 12'd3, 0, 1, 64'h0000_0000_ABCD_E777});

    foreach (vecs[i]) begin
      bus.lk_valid = vecs[i].lk; bus.ins_valid = vecs[i].ins;
      bus.lk_va = vecs[i].va; bus.ins_va = vecs[i].va; bus.ins_pa = vecs[i].pa;
      bus.lk_pcid = vecs[i].pcid; bus.ins_pcid = vecs[i].pcid; bus.ins_global = vecs[i].glob;
      tick();
      if (vecs[i].lk) begin
        chk($sformatf("vec%0d_valid", i), 64'(bus.rsp_valid), 64'd1);
        chk($sformatf("vec%0d_hitmiss", i), {62'd0, bus.rsp_hit, bus.rsp_miss},
            {62'd0, vecs[i].ehit, !vecs[i].ehit});
        chk($sformatf("vec%0d_pa", i), bus.rsp_pa, vecs[i].epa);
      end else begin
        chk($sformatf("vec%0d_norsp", i), {61'd0, bus.rsp_valid, bus.rsp_hit, bus.rsp_miss}, 64'd0);
      end
    end
    idle_inputs();

    // Invalidate pcid 1: pcid-0 and global entries survive.
    shutdown = 1; tick(); shutdown = 0;
    do_insert(64'h0000_0000_0001_2000, 64'h0000_0000_0AAA_A000, 12'd0, 0);
    do_insert(64'h0000_0000_0001_3000, 64'h0000_0000_0BBB_B000, 12'd1, 0);
    do_insert(64'h0000_0000_0002_2000, 64'h0000_0000_0CCC_C000, 12'd1, 0);
    do_insert(64'h0000_0000_0003_4000, 64'h0000_0000_0DDD_D000, 12'd1, 1);
    pulse_inv(0, 12'd1);
    wait_walk("inv1");
    do_lookup("inv1_a", 64'h0000_0000_0001_2010, 12'd0, 1, 64'h0000_0000_0AAA_A010);
    do_lookup("inv1_b", 64'h0000_0000_0001_3010, 12'd1, 0, 64'd0);
    do_lookup("inv1_c", 64'h0000_0000_0002_2010, 12'd1, 0, 64'd0);
    do_lookup("inv1_d", 64'h0000_0000_0003_4010, 12'd1, 1, 64'h0000_0000_0DDD_D010);

    // Invalidate-all clears global entries too.
    pulse_inv(1, 12'd0);
    wait_walk("invall");
    do_lookup("invall_d", 64'h0000_0000_0003_4010, 12'd1, 0, 64'd0);

    // Shutdown in the third busy cycle aborts the walk and flushes everything.
    do_insert(64'h0000_0000_0001_2000, 64'h0000_0000_0AAA_A000, 12'd0, 0);
    do_insert(64'h0000_0000_0003_4000, 64'h0000_0000_0DDD_D000, 12'd1, 1);
    pulse_inv(0, 12'd7);
    tick(); tick();
    shutdown = 1; tick(); shutdown = 0;
    chk("abort_busy", 64'(bus.inv_busy), 64'd0);
    chk("abort_ready", 64'(bus.lk_ready), 64'd1);
    do_lookup("abort_a", 64'h0000_0000_0001_2010, 12'd0, 0, 64'd0);
    do_lookup("abort_d", 64'h0000_0000_0003_4010, 12'd1, 0, 64'd0);

    // Random traffic against the model; global tags (6,7) are kept apart from
    // per-pcid tags (0..5) so no lookup ever matches two entries.
    m_reset();
    for (int it = 0; it < 500; it++) begin
      r = $urandom_range(0, 99);
      if (r < 4) begin
        glob = ($urandom_range(0, 3) == 0);
        pcid = 12'($urandom_range(0, 2));
        pulse_inv(glob, pcid);
        m_invalidate(glob, pcid);
        wait_walk("rnd_inv");
      end else begin
        do_lk  = ($urandom_range(0, 99) < 65);
        do_ins = ($urandom_range(0, 99) < 45);
        glob   = ($urandom_range(0, 9) == 0);
        tg     = 49'(glob ? $urandom_range(6, 7) : $urandom_range(0, 5));
        tg     = (tg << 40) | tg;
        bus.ins_va = {tg, 3'($urandom_range(0, 7)), 12'($urandom)};
        bus.ins_pa = {$urandom, $urandom};
        bus.ins_pcid = 12'($urandom_range(0, 2));
        bus.ins_global = glob;
        tg = 49'($urandom_range(0, 7));
        tg = (tg << 40) | tg;
        va = {tg, 3'($urandom_range(0, 7)), 12'($urandom)};
        pcid = 12'($urandom_range(0, 2));
        bus.lk_va = va; bus.lk_pcid = pcid;
        bus.lk_valid = do_lk; bus.ins_valid = do_ins;
        #1;
        chk("rnd_ready", 64'(bus.lk_ready), 64'd1);
        m_lookup(va, pcid, mhit, mpa, mway);
        tick();
        bus.lk_valid = 0; bus.ins_valid = 0;
        if (do_lk) begin
          chk("rnd_rsp", {61'd0, bus.rsp_valid, bus.rsp_hit, bus.rsp_miss},
              {61'd0, 1'b1, mhit, !mhit});
          chk("rnd_pa", bus.rsp_pa, mpa);
          if (mhit && !(do_ins && bus.ins_va[14:12] == va[14:12]))
            m_touch(int'(va[14:12]), mway);
        end else begin
          chk("rnd_norsp", {61'd0, bus.rsp_valid, bus.rsp_hit, bus.rsp_miss}, 64'd0);
        end
        if (do_ins) begin
          pa = bus.ins_pa;
          m_insert(bus.ins_va, pa, bus.ins_pcid, glob);
        end
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
